// File: rtl/calc_pkg.sv
// calc_pkg: shared button indices and debounce state encoding for the calculator front-end
package calc_pkg;
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;
  localparam int NUM_BTN = 5;
  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel with two-flop synchroniser, debounce FSM, level and press strobe
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  db_state_t state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      state <= STABLE_LO;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      pulse <= 1'b0;
      case (state)
        STABLE_LO: if (s2) begin
          state <= CHK_HI;
          cnt <= CNT_W'(1);
        end
        CHK_HI: if (!s2) begin
          state <= STABLE_LO;
          cnt <= '0;
        end else if (cnt == LAST) begin
          state <= STABLE_HI;
          level <= 1'b1;
          pulse <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + CNT_W'(1);
        STABLE_HI: if (!s2) begin
          state <= CHK_LO;
          cnt <= CNT_W'(1);
        end
        CHK_LO: if (s2) begin
          state <= STABLE_HI;
          cnt <= '0;
        end else if (cnt == LAST) begin
          state <= STABLE_LO;
          level <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + CNT_W'(1);
      endcase
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises switches, debounces buttons and snapshots switches on any press
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [15:0] sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic btn_any,
  output logic [15:0] sw_sync,
  output logic [15:0] sw_snap
);
  logic [15:0] sw_s1;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end
  assign btn_any = |btn_pulse;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_sync <= '0;
      sw_snap <= '0;
    end else begin
      sw_s1 <= sw_raw;
      sw_sync <= sw_s1;
      sw_snap <= btn_any ? sw_sync : sw_snap;
    end
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench with a sample-window debounce model
module tb_btn_conditioner;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [15:0] sw_raw = '0;
  logic [4:0] btn_level, btn_pulse;
  logic btn_any;
  logic [15:0] sw_sync, sw_snap;
  btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_any(btn_any),
    .sw_sync(sw_sync),
    .sw_snap(sw_snap)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [4:0] level;
    logic [4:0] pulse;
    logic any;
    logic [15:0] sws;
    logic [15:0] snap;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [4:0] hist[D+1];
  logic [15:0] sw_prev, m_sws, m_snap;
  logic [4:0] m_lvl, m_pls;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_clear();
    for (int k = 0; k <= D; k++) hist[k] = '0;
    sw_prev = '0;
    m_sws = '0;
    m_snap = '0;
    m_lvl = '0;
    m_pls = '0;
  endfunction
  // A level flips once the D raw samples taken 2..D+1 edges ago all disagree with it.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    bit diff;
    if (!rst_n) model_clear();
    else begin
      m_snap = (|m_pls) ? m_sws : m_snap;
      m_sws = sw_prev;
      sw_prev = sw_raw;
      for (int b = 0; b < 5; b++) begin
        diff = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[k][b] == m_lvl[b]) diff = 1'b0;
        m_pls[b] = 1'b0;
        if (diff) begin
          m_lvl[b] = ~m_lvl[b];
          m_pls[b] = m_lvl[b];
        end
      end
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn_raw;
    end
    e.level = m_lvl;
    e.pulse = m_pls;
    e.any = |m_pls;
    e.sws = m_sws;
    e.snap = m_snap;
    sb.push_back(e);
  end
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("btn_level", 32'(btn_level), 32'(e.level));
        chk("btn_pulse", 32'(btn_pulse), 32'(e.pulse));
        chk("btn_any", 32'(btn_any), 32'(e.any));
        chk("sw_sync", 32'(sw_sync), 32'(e.sws));
        chk("sw_snap", 32'(sw_snap), 32'(e.snap));
      end
    end
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int pulses;
    logic [0:6] bounce_hi;
    logic [0:5] bounce_lo;
    bounce_hi = 7'b1101111;
    bounce_lo = 6'b010000;
    model_clear();
    step(3);
    rst_n = 1'b1;
    step(2);
    btn_raw[0] = 1'b1;
    step(20);
    btn_raw[0] = 1'b0;
    step(10);
    for (int k = 0; k < 7; k++) begin
      btn_raw[4] = bounce_hi[k];
      step(1);
    end
    step(10);
    for (int k = 0; k < 6; k++) begin
      btn_raw[4] = bounce_lo[k];
      step(1);
    end
    step(10);
    sw_raw = 16'hBEEF;
    step(4);
    btn_raw[2] = 1'b1;
    btn_raw[4] = 1'b1;
    step(12);
    chk("snap_beef", 32'(sw_snap), 32'h0000BEEF);
    sw_raw = 16'h0001;
    step(6);
    chk("snap_hold", 32'(sw_snap), 32'h0000BEEF);
    btn_raw = '0;
    step(12);
    btn_raw[1] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_level", 32'(btn_level), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(12);
    btn_raw = '0;
    step(10);
    pulses = 0;
    btn_raw[3] = 1'b1;
    repeat (1000) begin
      @(posedge clk);
      #1 pulses += int'(btn_pulse[3]);
    end
    chk("long_hold_pulses", 32'(pulses), 32'd1);
    @(negedge clk);
    btn_raw = '0;
    step(10);
    repeat (150) begin
      if ($urandom_range(0, 2) == 0) btn_raw = 5'($urandom);
      else btn_raw[$urandom_range(0, 4)] ^= 1'b1;
      sw_raw = 16'($urandom);
      step($urandom_range(1, 10));
    end
    step(10);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
